eth_link_supervisor: RTL and testbench

//  Multi-port Ethernet link supervisor for the ethernet domain, between reset sync and NUM_PORTS PCS/PMA + PHY pairs.
//  Per port: sequences PHY/PCS reset, waits for PLL lock and auto-negotiation, debounces link-up and times out AN.

---
 rtl/eth_link_supervisor_pkg.sv | 23 ++
 rtl/eth_link_port_fsm.sv | 180 ++++++++++++++++++
 rtl/eth_link_supervisor.sv | 83 ++++++++
 tb/tb_eth_link_supervisor.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_link_supervisor_pkg.sv
// Shared encodings for the Ethernet link supervisor:
// FSM states, status-vector bit positions and drop-counter width.
package eth_link_supervisor_pkg;

   typedef enum logic [2:0] {
      ST_RESET    = 3'd0,
      ST_WAIT_PLL = 3'd1,
      ST_WAIT_AN  = 3'd2,
      ST_DEBOUNCE = 3'd3,
      ST_UP       = 3'd4,
      ST_FAIL     = 3'd5
   } link_state_e;

   localparam int STAT_W        = 16;
   localparam int STAT_LINK_BIT = 0;
   localparam int STAT_SYNC_BIT = 1;
   localparam int DROP_W        = 8;

   function automatic logic [DROP_W-1:0] drop_inc(input logic [DROP_W-1:0] c);
      return (&c) ? c : c + DROP_W'(1);
   endfunction

endpackage

// File: rtl/eth_link_port_fsm.sv
// One supervised Ethernet port: reset sequencing, PLL/AN wait,
// link debounce, AN timeout with bounded retries, drop counting.
module eth_link_port_fsm
   import eth_link_supervisor_pkg::*;
#(
   parameter int PHY_RST_CYCLES  = 1000,
   parameter int DEBOUNCE_CYCLES = 125000,
   parameter int AN_TIMEOUT      = 12500000,
   parameter int MAX_RETRIES     = 3,
   parameter int CNT_W           = 24
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              restart_i,
   input  logic              clr_cnt_i,
   input  logic              pll_lock_i,
   input  logic              link_good_i,
   output logic              phy_rst_n_o,
   output logic              pcs_reset_o,
   output logic              an_restart_o,
   output logic              link_up_o,
   output logic              fail_o,
   output logic [2:0]        state_o,
   output logic [DROP_W-1:0] drop_cnt_o
);

   // The good cycle seen in WAIT_AN counts as the first debounce cycle.
   localparam logic [CNT_W-1:0] RST_LAST =
      CNT_W'(PHY_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST =
      CNT_W'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0);
   localparam logic [CNT_W-1:0] AN_LAST =
      CNT_W'(AN_TIMEOUT - 1);
   localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);
   localparam bit DEB_ONE = (DEBOUNCE_CYCLES == 1);

   link_state_e       state_q;
   logic [CNT_W-1:0]  tmr_q;
   logic [CNT_W-1:0]  an_tmr_q;
   logic [3:0]        retry_q;
   logic [3:0]        retry_nx;
   logic [DROP_W-1:0] drop_q;
   logic [DROP_W-1:0] drop_d;
   logic              phy_rst_n_q;
   logic              pcs_reset_q;
   logic              an_restart_q;
   logic              link_up_q;
   logic              fail_q;
   logic              drop_ev;
   logic              an_to;

   assign an_to    = (an_tmr_q == AN_LAST);
   assign retry_nx = retry_q + 4'd1;

   // Drop counter next value: clear first, then a coincident drop lands at 1.
   always_comb begin
      drop_ev = en_i & ~restart_i & (state_q == ST_UP)
              & (~pll_lock_i | ~link_good_i);
      drop_d  = clr_cnt_i ? '0 : drop_q;
      if (drop_ev) begin
         drop_d = drop_inc(drop_d);
      end
   end

   // Port FSM with timers and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_RESET;
         tmr_q        <= '0;
         an_tmr_q     <= '0;
         retry_q      <= '0;
         drop_q       <= '0;
         phy_rst_n_q  <= 1'b0;
         pcs_reset_q  <= 1'b1;
         an_restart_q <= 1'b0;
         link_up_q    <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         an_restart_q <= 1'b0;
         drop_q       <= drop_d;
         if (!en_i || restart_i) begin
            state_q     <= ST_RESET;
            tmr_q       <= '0;
            retry_q     <= '0;
            phy_rst_n_q <= 1'b0;
            pcs_reset_q <= 1'b1;
            link_up_q   <= 1'b0;
            fail_q      <= 1'b0;
         end else begin
            unique case (state_q)
               ST_RESET: begin
                  if (tmr_q == RST_LAST) begin
                     state_q     <= ST_WAIT_PLL;
                     tmr_q       <= '0;
                     phy_rst_n_q <= 1'b1;
                     pcs_reset_q <= 1'b0;
                  end else begin
                     tmr_q <= tmr_q + CNT_W'(1);
                  end
               end
               ST_WAIT_PLL: begin
                  if (pll_lock_i) begin
                     state_q      <= ST_WAIT_AN;
                     an_tmr_q     <= '0;
                     an_restart_q <= 1'b1;
                  end
               end
               ST_WAIT_AN, ST_DEBOUNCE: begin
                  if (!pll_lock_i) begin
                     state_q <= ST_WAIT_PLL;
                  end else if (an_to) begin
                     retry_q     <= retry_nx;
                     tmr_q       <= '0;
                     phy_rst_n_q <= 1'b0;
                     pcs_reset_q <= 1'b1;
                     if (retry_nx == RETRY_MAX) begin
                        state_q <= ST_FAIL;
                        fail_q  <= 1'b1;
                     end else begin
                        state_q <= ST_RESET;
                     end
                  end else begin
                     an_tmr_q <= an_tmr_q + CNT_W'(1);
                     if (state_q == ST_WAIT_AN) begin
                        if (link_good_i && DEB_ONE) begin
                           state_q   <= ST_UP;
                           link_up_q <= 1'b1;
                           retry_q   <= '0;
                        end else if (link_good_i) begin
                           state_q <= ST_DEBOUNCE;
                           tmr_q   <= '0;
                        end
                     end else if (!link_good_i) begin
                        state_q <= ST_WAIT_AN;
                     end else if (tmr_q == DEB_LAST) begin
                        state_q   <= ST_UP;
                        link_up_q <= 1'b1;
                        retry_q   <= '0;
                     end else begin
                        tmr_q <= tmr_q + CNT_W'(1);
                     end
                  end
               end
               ST_UP: begin
                  if (!pll_lock_i) begin
                     state_q   <= ST_WAIT_PLL;
                     link_up_q <= 1'b0;
                  end else if (!link_good_i) begin
                     state_q      <= ST_WAIT_AN;
                     an_tmr_q     <= '0;
                     an_restart_q <= 1'b1;
                     link_up_q    <= 1'b0;
                  end
               end
               ST_FAIL: begin
                  state_q <= ST_FAIL;
               end
               default: begin
                  state_q     <= ST_RESET;
                  tmr_q       <= '0;
                  phy_rst_n_q <= 1'b0;
                  pcs_reset_q <= 1'b1;
                  link_up_q   <= 1'b0;
                  fail_q      <= 1'b0;
               end
            endcase
         end
      end
   end

   assign phy_rst_n_o  = phy_rst_n_q;
   assign pcs_reset_o  = pcs_reset_q;
   assign an_restart_o = an_restart_q;
   assign link_up_o    = link_up_q;
   assign fail_o       = fail_q;
   assign state_o      = state_q;
   assign drop_cnt_o   = drop_q;

endmodule

// File: rtl/eth_link_supervisor.sv
// Multi-port Ethernet link supervisor: one FSM per port plus an
// aggregate link-up flag and system reset for the Ethernet domain.
module eth_link_supervisor
   import eth_link_supervisor_pkg::*;
#(
   parameter int NUM_PORTS       = 2,
   parameter int PHY_RST_CYCLES  = 1000,
   parameter int DEBOUNCE_CYCLES = 125000,
   parameter int AN_TIMEOUT      = 12500000,
   parameter int MAX_RETRIES     = 3,
   parameter int CNT_W           = 24
) (
   input  logic                        clk_eth_i,
   input  logic                        rst_eth_i,
   input  logic [NUM_PORTS-1:0]        port_en_i,
   input  logic [NUM_PORTS-1:0]        pll_lock_i,
   input  logic [STAT_W*NUM_PORTS-1:0] status_vec_i,
   input  logic [NUM_PORTS-1:0]        an_complete_i,
   input  logic [NUM_PORTS-1:0]        restart_i,
   input  logic                        clr_cnt_i,
   output logic [NUM_PORTS-1:0]        phy_rst_n_o,
   output logic [NUM_PORTS-1:0]        pcs_reset_o,
   output logic [NUM_PORTS-1:0]        an_restart_o,
   output logic [NUM_PORTS-1:0]        link_up_o,
   output logic [NUM_PORTS-1:0]        fail_o,
   output logic [3*NUM_PORTS-1:0]      state_o,
   output logic [DROP_W*NUM_PORTS-1:0] drop_cnt_o,
   output logic                        all_up_o,
   output logic                        eth_system_reset_o
);

   logic [NUM_PORTS-1:0] link_good;
   logic [NUM_PORTS-1:0] unused_status;
   logic                 all_up_q;
   logic                 sys_rst_q;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      assign link_good[i] =
         status_vec_i[STAT_W*i+STAT_LINK_BIT]
       & status_vec_i[STAT_W*i+STAT_SYNC_BIT]
       & an_complete_i[i];
      assign unused_status[i] =
         ^status_vec_i[STAT_W*i+2 +: STAT_W-2];

      eth_link_port_fsm #(
         .PHY_RST_CYCLES  (PHY_RST_CYCLES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .AN_TIMEOUT      (AN_TIMEOUT),
         .MAX_RETRIES     (MAX_RETRIES),
         .CNT_W           (CNT_W)
      ) u_fsm (
         .clk_i        (clk_eth_i),
         .rst_i        (rst_eth_i),
         .en_i         (port_en_i[i]),
         .restart_i    (restart_i[i]),
         .clr_cnt_i    (clr_cnt_i),
         .pll_lock_i   (pll_lock_i[i]),
         .link_good_i  (link_good[i]),
         .phy_rst_n_o  (phy_rst_n_o[i]),
         .pcs_reset_o  (pcs_reset_o[i]),
         .an_restart_o (an_restart_o[i]),
         .link_up_o    (link_up_o[i]),
         .fail_o       (fail_o[i]),
         .state_o      (state_o[3*i +: 3]),
         .drop_cnt_o   (drop_cnt_o[DROP_W*i +: DROP_W])
      );
   end

   // Aggregate up over enabled ports; system reset follows one cycle later.
   always_ff @(posedge clk_eth_i) begin
      if (rst_eth_i) begin
         all_up_q  <= 1'b0;
         sys_rst_q <= 1'b1;
      end else begin
         all_up_q  <= (|port_en_i) & (&(link_up_o | ~port_en_i));
         sys_rst_q <= ~all_up_q;
      end
   end

   assign all_up_o           = all_up_q;
   assign eth_system_reset_o = sys_rst_q;

endmodule

// File: tb/tb_eth_link_supervisor.sv
// Directed bench for eth_link_supervisor.
// Queued expectations checked on negedge.
module tb_eth_link_supervisor;

  localparam int NP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] port_en;
  logic [NP-1:0] pll_lock;
  logic [31:0]   status_vec;
  logic [NP-1:0] an_complete;
  logic [NP-1:0] restart;
  logic          clr_cnt;
  logic [NP-1:0] phy_rst_n;
  logic [NP-1:0] pcs_reset;
  logic [NP-1:0] an_restart;
  logic [NP-1:0] link_up;
  logic [NP-1:0] fail;
  logic [5:0]    state;
  logic [15:0]   drop_cnt;
  logic          all_up;
  logic          sys_rst;

  always #5 clk = ~clk;

  eth_link_supervisor #(
    .NUM_PORTS       (NP),
    .PHY_RST_CYCLES  (4),
    .DEBOUNCE_CYCLES (3),
    .AN_TIMEOUT      (20),
    .MAX_RETRIES     (2),
    .CNT_W           (24)
  ) dut (
    .clk_eth_i          (clk),
    .rst_eth_i          (rst),
    .port_en_i          (port_en),
    .pll_lock_i         (pll_lock),
    .status_vec_i       (status_vec),
    .an_complete_i      (an_complete),
    .restart_i          (restart),
    .clr_cnt_i          (clr_cnt),
    .phy_rst_n_o        (phy_rst_n),
    .pcs_reset_o        (pcs_reset),
    .an_restart_o       (an_restart),
    .link_up_o          (link_up),
    .fail_o             (fail),
    .state_o            (state),
    .drop_cnt_o         (drop_cnt),
    .all_up_o           (all_up),
    .eth_system_reset_o (sys_rst)
  );

  typedef enum int {
    F_PHY, F_PCS, F_ANR, F_UP, F_FAIL,
    F_ST, F_DROP, F_ALL, F_SYS
  } field_e;

  typedef struct {
    string  name;
    field_e f;
    int     p;
    int     v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  function automatic int probe(field_e f, int p);
    case (f)
      F_PHY:   return int'(phy_rst_n[p]);
      F_PCS:   return int'(pcs_reset[p]);
      F_ANR:   return int'(an_restart[p]);
      F_UP:    return int'(link_up[p]);
      F_FAIL:  return int'(fail[p]);
      F_ST:    return int'(state[3*p +: 3]);
      F_DROP:  return int'(drop_cnt[8*p +: 8]);
      F_ALL:   return int'(all_up);
      default: return int'(sys_rst);
    endcase
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    int   got;
    while (q.size() > 0) begin
      e   = q.pop_front();
      got = probe(e.f, e.p);
      checks++;
      if (got == e.v) passed++;
      else $display("FAIL %s port%0d: got %0d expected %0d",
                    e.name, e.p, got, e.v);
    end
  end

  task automatic chk(string n, field_e f, int p, int v);
    q.push_back('{n, f, p, v});
  endtask

  task automatic direct(string n, bit ok);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s", n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_good(logic [NP-1:0] g);
    for (int p = 0; p < NP; p++) begin
      status_vec[16*p+0] = g[p];
      status_vec[16*p+1] = g[p];
      an_complete[p]     = g[p];
    end
  endtask

  task automatic chk_reset(string n);
    for (int p = 0; p < NP; p++) begin
      chk({n, "_st"},   F_ST,   p, 0);
      chk({n, "_phy"},  F_PHY,  p, 0);
      chk({n, "_pcs"},  F_PCS,  p, 1);
      chk({n, "_anr"},  F_ANR,  p, 0);
      chk({n, "_up"},   F_UP,   p, 0);
      chk({n, "_fail"}, F_FAIL, p, 0);
      chk({n, "_drop"}, F_DROP, p, 0);
    end
    chk({n, "_all"}, F_ALL, 0, 0);
    chk({n, "_sys"}, F_SYS, 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_drop;
    rst         = 1'b1;
    port_en     = 2'b11;
    pll_lock    = 2'b00;
    an_complete = 2'b00;
    restart     = 2'b00;
    clr_cnt     = 1'b0;
    status_vec  = 32'h4080_4080;
    repeat (3) tick();
    chk_reset("por");
    direct("por_phy_direct", phy_rst_n == 2'b00);

    rst      = 1'b0;
    pll_lock = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_pulse_phy", F_PHY, 0, int'(k == 3));
      chk("rst_pulse_phy", F_PHY, 1, int'(k == 3));
    end
    chk("wait_pll_st", F_ST, 0, 1);
    chk("wait_pll_pcs", F_PCS, 0, 0);
    tick();
    chk("an_restart", F_ANR, 0, 1);
    chk("an_restart", F_ANR, 1, 1);
    chk("wait_an_st", F_ST, 0, 2);
    tick();
    chk("an_restart_end", F_ANR, 0, 0);
    set_good(2'b11);
    tick();
    chk("deb_st", F_ST, 0, 3);
    chk("deb_st", F_ST, 1, 3);
    tick();
    chk("deb_up", F_UP, 0, 0);
    set_good(2'b01);
    tick();
    chk("up_st", F_ST, 0, 4);
    chk("up_rise", F_UP, 0, 1);
    chk("glitch_st", F_ST, 1, 2);
    chk("glitch_up", F_UP, 1, 0);
    chk("all_up_wait", F_ALL, 0, 0);
    set_good(2'b11);
    tick();
    chk("glitch_deb", F_ST, 1, 3);
    tick();
    chk("all_up_wait2", F_ALL, 0, 0);
    tick();
    chk("glitch_up_st", F_ST, 1, 4);
    chk("glitch_up_rise", F_UP, 1, 1);
    chk("sys_before", F_SYS, 0, 1);
    tick();
    chk("all_up_rise", F_ALL, 0, 1);
    chk("sys_lag", F_SYS, 0, 1);
    tick();
    chk("sys_fall", F_SYS, 0, 0);
    chk("no_drop", F_DROP, 0, 0);
    chk("no_drop", F_DROP, 1, 0);
    direct("both_up_direct", link_up == 2'b11);

    pll_lock = 2'b10;
    tick();
    chk("pll_loss_st", F_ST, 0, 1);
    chk("pll_loss_up", F_UP, 0, 0);
    chk("pll_loss_drop", F_DROP, 0, 1);
    chk("pll_loss_phy", F_PHY, 0, 1);
    tick();
    chk("pll_loss_all", F_ALL, 0, 0);
    tick();
    chk("pll_loss_sys", F_SYS, 0, 1);
    pll_lock = 2'b11;
    tick();
    chk("relock_st", F_ST, 0, 2);
    chk("relock_anr", F_ANR, 0, 1);
    repeat (3) tick();
    chk("relock_up", F_ST, 0, 4);
    repeat (2) tick();
    chk("relock_sys", F_SYS, 0, 0);

    exp_drop = 1;
    for (int k = 0; k < 300; k++) begin
      set_good(2'b10);
      tick();
      exp_drop = (exp_drop == 255) ? 255 : exp_drop + 1;
      chk("drop_cnt", F_DROP, 0, exp_drop);
      set_good(2'b11);
      repeat (3) tick();
    end
    chk("drop_sat", F_DROP, 0, 255);
    chk("drop_loop_st", F_ST, 0, 4);
    set_good(2'b10);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_with_drop", F_DROP, 0, 1);
    chk("clr_other", F_DROP, 1, 0);
    set_good(2'b11);
    repeat (3) tick();
    chk("reup_st", F_ST, 0, 4);
    repeat (2) tick();
    chk("reup_all", F_ALL, 0, 1);
    chk("reup_sys", F_SYS, 0, 0);

    port_en = 2'b01;
    tick();
    chk("dis_st", F_ST, 1, 0);
    chk("dis_up", F_UP, 1, 0);
    chk("dis_phy", F_PHY, 1, 0);
    chk("dis_pcs", F_PCS, 1, 1);
    tick();
    chk("dis_all_p0", F_ALL, 0, 1);
    chk("dis_sys_p0", F_SYS, 0, 0);
    port_en = 2'b00;
    tick();
    chk("dis_all_none", F_ALL, 0, 0);
    chk("dis_st0", F_ST, 0, 0);
    tick();
    chk("dis_sys_none", F_SYS, 0, 1);
    direct("dis_all_direct", all_up == 1'b0);

    port_en = 2'b01;
    set_good(2'b00);
    for (int a = 0; a < 2; a++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        chk("retry_phy", F_PHY, 0, int'(k == 3));
      end
      tick();
      chk("retry_wait_an", F_ST, 0, 2);
      for (int t = 1; t <= 20; t++) begin
        tick();
        if (t == 19) chk("to_pre", F_ST, 0, 2);
      end
      chk("to_st", F_ST, 0, (a == 0) ? 0 : 5);
      chk("to_phy", F_PHY, 0, 0);
      chk("to_pcs", F_PCS, 0, 1);
      chk("to_fail", F_FAIL, 0, (a == 0) ? 0 : 1);
    end
    repeat (5) tick();
    chk("fail_hold_st", F_ST, 0, 5);
    chk("fail_hold", F_FAIL, 0, 1);
    restart = 2'b01;
    tick();
    restart = 2'b00;
    chk("restart_st", F_ST, 0, 0);
    chk("restart_fail", F_FAIL, 0, 0);
    chk("restart_phy", F_PHY, 0, 0);
    direct("restart_fail_direct", fail == 2'b00);

    port_en = 2'b11;
    set_good(2'b11);
    repeat (6) tick();
    chk("pre_rst_st", F_ST, 0, 3);
    chk("pre_rst_st", F_ST, 1, 3);
    rst = 1'b1;
    tick();
    chk_reset("mid_rst");
    direct("mid_rst_pcs_direct", pcs_reset == 2'b11);
    direct("mid_rst_anr_direct", an_restart == 2'b00);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    if (passed == checks && checks >= 12) $display("PASS");
    else $display("FAIL summary");
    $finish;
  end

endmodule
